// File: rtl/dac_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// dac_cmd_scheduler
//
// Arbitrates DAC code-write requests from N_CH stimulation channels and hands
// one 24-bit frame at a time to an SPI master. Channels are served round-robin
// starting after the most recently granted channel. Every frame is followed by
// GAP_CYC idle cycles so the DAC latch can relax before the next write.
//
// Optional feature (macro DAC_SCHED_INIT_EN):
//   When defined, the block starts in INIT after reset and first sends the DAC
//   control-register frame {8'h02, INIT_CTRL_WORD}. That frame runs through
//   ISSUE, WAIT_DONE and GAP like any other, but it is not counted and no
//   channel is granted until the first IDLE. When undefined, reset goes
//   straight to IDLE and INIT_CTRL_WORD is unused.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   req_valid    per-channel write request
//   req_data     per-channel 16-bit DAC code, channel i at [16i+15:16i]
//   req_ready    per-channel accept, one-hot or zero, only asserted in IDLE
//   spi_valid    frame offered to the SPI master
//   spi_frame    {address byte, payload}
//   spi_ready    SPI master takes the frame
//   spi_done     one-cycle pulse when the frame is shifted out and latched
//   busy         high whenever the scheduler is not in IDLE
//   last_ch      index of the most recently granted channel
//   frame_count  completed channel frames, wraps at 16'hFFFF
// -----------------------------------------------------------------------------
module dac_cmd_scheduler #(
  parameter int          N_CH           = 4,
  parameter int          IDX_W          = 2,
  parameter int          GAP_CYC        = 6,
  parameter logic [15:0] INIT_CTRL_WORD = 16'h0012
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      req_valid,
  input  logic [16*N_CH-1:0]   req_data,
  output logic [N_CH-1:0]      req_ready,
  output logic                 spi_valid,
  output logic [23:0]          spi_frame,
  input  logic                 spi_ready,
  input  logic                 spi_done,
  output logic                 busy,
  output logic [IDX_W-1:0]     last_ch,
  output logic [15:0]          frame_count
);

`ifdef DAC_SCHED_INIT_EN
  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;
  localparam state_t RESET_STATE = ST_INIT;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t           state;
  logic [3:0]       gap_cnt;
  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand_idx;
  int               cand;
  logic             accept;

`ifdef DAC_SCHED_INIT_EN
  // Marks the control-register frame so its completion is not counted.
  logic init_frame;
`else
  logic unused_init_word;
  assign unused_init_word = ^INIT_CTRL_WORD;
`endif

  assign busy = (state != ST_IDLE);

  // Round-robin search: look at last_ch+1, last_ch+2, ... wrapping modulo
  // N_CH, and take the first channel that is requesting. last_ch itself is
  // checked last, so a lone requester can still be served back to back.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand     = (int'(last_ch) + k) % N_CH;
      cand_idx = cand[IDX_W-1:0];
      if (!grant_any && req_valid[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // Grant is offered combinationally, and only while idle.
  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RESET_STATE;
      spi_valid   <= 1'b0;
      spi_frame   <= 24'h0;
      last_ch     <= IDX_W'(N_CH - 1);
      frame_count <= 16'h0;
      gap_cnt     <= 4'h0;
`ifdef DAC_SCHED_INIT_EN
      init_frame  <= 1'b0;
`endif
    end else begin
      case (state)
`ifdef DAC_SCHED_INIT_EN
        ST_INIT: begin
          spi_frame  <= {8'h02, INIT_CTRL_WORD};
          spi_valid  <= 1'b1;
          init_frame <= 1'b1;
          state      <= ST_ISSUE;
        end
`endif
        ST_IDLE: begin
          if (accept) begin
            spi_frame <= {8'h01, req_data[{grant_idx, 4'b0000} +: 16]};
            spi_valid <= 1'b1;
            last_ch   <= grant_idx;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (spi_ready) begin
            spi_valid <= 1'b0;
            state     <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (spi_done) begin
`ifdef DAC_SCHED_INIT_EN
            if (!init_frame) begin
              frame_count <= frame_count + 16'd1;
            end
            init_frame <= 1'b0;
`else
            frame_count <= frame_count + 16'd1;
`endif
            gap_cnt <= 4'(GAP_CYC);
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          // Loaded with GAP_CYC, leaving on the cycle it reads 1 gives
          // exactly GAP_CYC cycles here.
          gap_cnt <= gap_cnt - 4'd1;
          if (gap_cnt <= 4'd1) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= RESET_STATE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dac_cmd_scheduler
//
// Directed testbench for dac_cmd_scheduler with default parameters
// (N_CH=4, GAP_CYC=6). Inputs change 1 ns after a rising edge and outputs are
// sampled 1 ns after that, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_dac_cmd_scheduler;

  localparam int N_CH    = 4;
  localparam int IDX_W   = 2;
  localparam int GAP_CYC = 6;

  logic                clk;
  logic                rst;
  logic [N_CH-1:0]     req_valid;
  logic [16*N_CH-1:0]  req_data;
  logic [N_CH-1:0]     req_ready;
  logic                spi_valid;
  logic [23:0]         spi_frame;
  logic                spi_ready;
  logic                spi_done;
  logic                busy;
  logic [IDX_W-1:0]    last_ch;
  logic [15:0]         frame_count;

  int checks = 0;
  int errors = 0;

  dac_cmd_scheduler #(
    .N_CH(N_CH),
    .IDX_W(IDX_W),
    .GAP_CYC(GAP_CYC),
    .INIT_CTRL_WORD(16'h0012)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .spi_valid(spi_valid),
    .spi_frame(spi_frame),
    .spi_ready(spi_ready),
    .spi_done(spi_done),
    .busy(busy),
    .last_ch(last_ch),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the handshake inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic [N_CH-1:0] valid, input logic ready, input logic done);
    req_valid = valid;
    spi_ready = ready;
    spi_done  = done;
    #1;
  endtask

  initial begin
    logic [23:0] exp_frame;
    logic        busy_rst;
    int          exp_ch;

`ifdef DAC_SCHED_INIT_EN
    busy_rst = 1'b1;
`else
    busy_rst = 1'b0;
`endif

    // ---------------- reset values ----------------
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    spi_ready = 1'b0;
    spi_done  = 1'b0;
    tick();
    tick();
    checkOutput("rst_spi_valid",   24'(spi_valid),   24'h0);
    checkOutput("rst_spi_frame",   spi_frame,        24'h0);
    checkOutput("rst_last_ch",     24'(last_ch),     24'h3);
    checkOutput("rst_frame_count", 24'(frame_count), 24'h0);
    checkOutput("rst_req_ready",   24'(req_ready),   24'h0);
    checkOutput("rst_busy",        24'(busy),        24'(busy_rst));

`ifdef DAC_SCHED_INIT_EN
    // ---------------- init control frame ----------------
    applyStimulus(4'b1111, 1'b1, 1'b0);
    rst = 1'b0;
    tick();
    checkOutput("init_spi_valid", 24'(spi_valid), 24'h1);
    checkOutput("init_frame",     spi_frame,      24'h020012);
    checkOutput("init_req_ready", 24'(req_ready), 24'h0);
    tick();
    checkOutput("init_wait_valid", 24'(spi_valid), 24'h0);
    applyStimulus(4'b1111, 1'b1, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < GAP_CYC; i++) begin
      checkOutput("init_gap_ready", 24'(req_ready), 24'h0);
      tick();
    end
    checkOutput("init_idle_busy",  24'(busy),        24'h0);
    checkOutput("init_frame_count", 24'(frame_count), 24'h0);
`else
    rst = 1'b0;
    #1;
`endif

    // ---------------- single request, ch2, with backpressure ----------------
    req_data[2*16 +: 16] = 16'hABCD;
    applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOutput("single_req_ready", 24'(req_ready), 24'h4);
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("single_spi_valid", 24'(spi_valid), 24'h1);
    checkOutput("single_spi_frame", spi_frame,      24'h01ABCD);
    checkOutput("single_last_ch",   24'(last_ch),   24'h2);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp_spi_valid", 24'(spi_valid), 24'h1);
      checkOutput("bp_spi_frame", spi_frame,      24'h01ABCD);
      checkOutput("bp_req_ready", 24'(req_ready), 24'h0);
    end
    applyStimulus(4'b0000, 1'b1, 1'b0);
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("xfer_spi_valid", 24'(spi_valid), 24'h0);
    checkOutput("xfer_busy",      24'(busy),      24'h1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    tick();
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("single_frame_count", 24'(frame_count), 24'h1);
    // GAP: exactly GAP_CYC cycles busy with no grants even though all request.
    for (int i = 0; i < GAP_CYC; i++) begin
      checkOutput("gap_busy",      24'(busy),      24'h1);
      checkOutput("gap_req_ready", 24'(req_ready), 24'h0);
      tick();
    end
    checkOutput("gap_end_busy", 24'(busy), 24'h0);
    // last_ch=2, so with everyone requesting channel 3 is next.
    checkOutput("gap_end_req_ready", 24'(req_ready), 24'h8);

    // ---------------- requester withdraws before accept ----------------
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("drop_spi_valid", 24'(spi_valid), 24'h0);
    checkOutput("drop_last_ch",   24'(last_ch),   24'h2);

    // ---------------- stray spi_done in IDLE ----------------
    applyStimulus(4'b0000, 1'b0, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("stray_frame_count", 24'(frame_count), 24'h1);
    checkOutput("stray_busy",        24'(busy),        24'h0);

    // ---------------- ch1 request, then reset in WAIT_DONE ----------------
    req_data[1*16 +: 16] = 16'h1234;
    applyStimulus(4'b0010, 1'b1, 1'b0);
    checkOutput("ch1_req_ready", 24'(req_ready), 24'h2);
    tick();
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("ch1_spi_frame", spi_frame,    24'h011234);
    checkOutput("ch1_last_ch",   24'(last_ch), 24'h1);
    tick();
    checkOutput("ch1_wait_valid", 24'(spi_valid), 24'h0);
    checkOutput("ch1_wait_busy",  24'(busy),      24'h1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_spi_valid",   24'(spi_valid),   24'h0);
    checkOutput("midrst_spi_frame",   spi_frame,        24'h0);
    checkOutput("midrst_frame_count", 24'(frame_count), 24'h0);
    checkOutput("midrst_last_ch",     24'(last_ch),     24'h3);
    tick();

`ifdef DAC_SCHED_INIT_EN
    // Run the init frame again before round-robin.
    applyStimulus(4'b0000, 1'b1, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    applyStimulus(4'b0000, 1'b1, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < GAP_CYC; i++) tick();
`else
    rst = 1'b0;
    #1;
`endif

    // ---------------- round-robin with all channels requesting ----------------
    for (int i = 0; i < N_CH; i++) begin
      req_data[i*16 +: 16] = 16'hC000 + 16'(i);
    end
    for (int k = 0; k < 5; k++) begin
      exp_ch    = k % N_CH;
      exp_frame = {8'h01, 16'hC000 + 16'(exp_ch)};
      applyStimulus(4'b1111, 1'b1, 1'b0);
      checkOutput($sformatf("rr%0d_req_ready", k), 24'(req_ready), 24'(1 << exp_ch));
      tick();
      checkOutput($sformatf("rr%0d_spi_frame", k), spi_frame,    exp_frame);
      checkOutput($sformatf("rr%0d_last_ch", k),   24'(last_ch), 24'(exp_ch));
      tick();
      applyStimulus(4'b1111, 1'b1, 1'b1);
      tick();
      applyStimulus(4'b1111, 1'b1, 1'b0);
      checkOutput($sformatf("rr%0d_frame_count", k), 24'(frame_count), 24'(k + 1));
      for (int i = 0; i < GAP_CYC; i++) tick();
      checkOutput($sformatf("rr%0d_idle", k), 24'(busy), 24'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_cmd_scheduler.md
DAC_CMD_SCHEDULER -- requirements
Module: dac_cmd_scheduler

Interface
REQ-001 Parameter N_CH, default 4, number of requesting stimulation channels (2..8).
REQ-002 Parameter IDX_W, default 2, channel index width, SHALL equal ceil(log2(N_CH)).
REQ-003 Parameter GAP_CYC, default 6, idle cycles between frames for latch relax (1..15).
REQ-004 Parameter INIT_CTRL_WORD, default 16'h0012, DAC control-register payload sent after reset.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 req_valid  in  N_CH  per-channel code-write request.
REQ-008 req_data  in  16*N_CH  per-channel 16-bit DAC code; channel i at bits [16i+15:16i].
REQ-009 req_ready  out  N_CH  per-channel accept; one-hot or zero.
REQ-010 spi_valid  out  1  frame offer to SPI master.
REQ-011 spi_frame  out  24  {address byte, payload}.
REQ-012 spi_ready  in  1  SPI master accepts frame.
REQ-013 spi_done  in  1  single-cycle pulse, frame shifted and latched.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 last_ch  out  IDX_W  index of most recently granted channel.
REQ-016 frame_count  out  16  completed channel frames, wraps 16'hFFFF -> 0.

Function
REQ-017 States: INIT, IDLE, ISSUE, WAIT_DONE, GAP; held in a registered state machine.
REQ-018 IDLE: req_ready SHALL be asserted combinationally only for the round-robin winner among req_valid bits; all zero if no req_valid.
REQ-019 Round-robin: search starts at last_ch+1 modulo N_CH; winner is first set req_valid bit found.
REQ-020 Accept occurs on a cycle with req_valid[i] & req_ready[i]; at that edge the block SHALL capture spi_frame = {8'h01, req_data[i]}, set last_ch = i, go to ISSUE.
REQ-021 A requester dropping req_valid before accept SHALL receive no grant and no frame.
REQ-022 ISSUE: spi_valid = 1, spi_frame stable; transfer on cycle spi_valid & spi_ready; next state WAIT_DONE, spi_valid deasserts.
REQ-023 Latency: accept at cycle t -> spi_valid high at t+1.
REQ-024 WAIT_DONE: on spi_done, frame_count increments by 1 (channel frames only), next state GAP with gap counter loaded to GAP_CYC.
REQ-025 spi_done outside WAIT_DONE SHALL be ignored (no count, no state change).
REQ-026 GAP: counter decrements each cycle; on reaching 1 next state is IDLE; exactly GAP_CYC cycles spent in GAP.
REQ-027 req_ready SHALL be zero in every state except IDLE.
REQ-028 No timeout: WAIT_DONE holds indefinitely until spi_done.

Reset
REQ-029 On rst: req_ready = 0, spi_valid = 0, spi_frame = 24'h0, busy per reset state, last_ch = N_CH-1 (channel 0 wins first), frame_count = 0, gap counter = 0.
REQ-030 rst asserted mid-operation SHALL drop spi_valid immediately and discard any captured frame; no partial-frame recovery.
REQ-031 Reset state is INIT when DAC_SCHED_INIT_EN is defined, otherwise IDLE.

Configuration
REQ-032 Macro DAC_SCHED_INIT_EN defined: after reset, INIT loads spi_frame = {8'h02, INIT_CTRL_WORD}, proceeds through ISSUE, WAIT_DONE, GAP before first IDLE; no grants during this; init frame not counted in frame_count.
REQ-033 Macro DAC_SCHED_INIT_EN undefined: no INIT state, reset goes directly to IDLE, INIT_CTRL_WORD unused.

Verification
REQ-034 Init (macro on): release rst, spi_ready=1, spi_done pulse 5 cycles later -> one frame 24'h020012, req_ready stays 0 until first IDLE, frame_count=0.
REQ-035 Single request: req_valid=4'b0100, ch2 data 16'hABCD -> req_ready=4'b0100 one cycle, spi_frame=24'h01ABCD next cycle, frame_count=1 after spi_done, last_ch=2.
REQ-036 Round-robin: req_valid=4'b1111 held, spi_ready=1, spi_done each frame -> grant order 0,1,2,3,0.
REQ-037 Backpressure/gap: spi_ready low 10 cycles -> spi_valid and spi_frame stable throughout; after spi_done exactly 6 cycles with busy=1, req_ready=0.
REQ-038 Stray/reset: spi_done pulse in IDLE -> frame_count unchanged; rst asserted during WAIT_DONE -> spi_valid=0, frame_count=0, last_ch=3.
